// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared states, status codes and exit-priority helper for the MIPS run controller
package mips_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RST1 = 3'd1;
  localparam state_t S_WARM = 3'd2;
  localparam state_t S_RST2 = 3'd3;
  localparam state_t S_RUN  = 3'd4;
  localparam state_t S_DONE = 3'd5;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_STALL   = 2'b11;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  // Halt beats stall beats timeout when several fire in the same RUN cycle.
  function automatic logic [1:0] exit_status(input logic halt, input logic stall,
                                             input logic timeout);
    if (halt)
      return ST_HALT;
    else if (stall)
      return ST_STALL;
    else if (timeout)
      return ST_TIMEOUT;
    else
      return ST_NONE;
  endfunction

endpackage

// File: rtl/mips_phase_cnt.sv
// rtl/mips_phase_cnt.sv - loadable down-counter timing the reset and warm-run phases
module mips_phase_cnt
  import mips_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;

  // Loaded with (phase length - 1) on phase entry; expired marks the last phase cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_value;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - reset/warm/re-reset/run sequencer for the MIPS core; MIPS_RUN_CTRL_WATCHDOG_EN adds stall detection
module mips_run_ctrl
  import mips_pkg::*;
#(
  parameter int              DATA_WIDTH   = 32,
  parameter int              RST_CYCLES   = 3,
  parameter int              WARM_CYCLES  = 3,
  parameter int              RUN_CYCLES   = 100,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(HALT_INSTR_DEFAULT),
  parameter int              STALL_CYCLES = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [DATA_WIDTH-1:0]           i_instruction,
  output logic                            o_core_rst,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [1:0]                      o_status,
  output logic                            o_reset_ok,
  output logic [$clog2(RUN_CYCLES+1)-1:0] o_cycle_cnt
);

  localparam int PH_MAX = (RST_CYCLES > WARM_CYCLES) ? RST_CYCLES : WARM_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = $clog2(RUN_CYCLES + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_first_cycle;
  logic                  w_load;
  logic [PH_W-1:0]       w_load_val;
  logic                  w_ph_expired;
  logic                  w_start_ok;
  logic [DATA_WIDTH-1:0] r_first_instr;
  logic [CNT_W-1:0]      r_cycle_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [1:0]            r_status;
  logic                  r_done;
  logic                  r_reset_ok;
  logic                  w_halt;
  logic                  w_stall;
  logic                  w_timeout;
  logic                  w_run_exit;

  mips_phase_cnt #(.WIDTH(PH_W)) u_phase_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst),
    .i_load    (w_load),
    .i_value   (w_load_val),
    .o_expired (w_ph_expired)
  );

  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_cnt_inc  = r_cycle_cnt + 1'b1;
  assign w_halt     = (i_instruction == HALT_INSTR);
  assign w_timeout  = (w_cnt_inc == CNT_W'(RUN_CYCLES));
  assign w_run_exit = w_halt || w_stall || w_timeout;

`ifdef MIPS_RUN_CTRL_WATCHDOG_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);

  logic [DATA_WIDTH-1:0] r_prev_instr;
  logic [SW-1:0]         r_stall_len;
  logic [SW-1:0]         w_stall_len;

  // Length of the current run of identical fetches, counting this cycle.
  always_comb begin
    w_stall_len = r_stall_len;
    if (r_first_cycle || i_instruction != r_prev_instr)
      w_stall_len = SW'(1);
    else if (r_stall_len != SW'(STALL_CYCLES))
      w_stall_len = r_stall_len + 1'b1;
  end

  assign w_stall = (r_state == S_RUN) && (w_stall_len >= SW'(STALL_CYCLES));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_prev_instr <= '0;
      r_stall_len  <= '0;
    end else begin
      r_prev_instr <= i_instruction;
      r_stall_len  <= (r_state == S_RUN) ? w_stall_len : '0;
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_next = S_RST1;
          w_load       = 1'b1;
          w_load_val   = PH_W'(RST_CYCLES - 1);
        end
      end
      S_RST1: begin
        if (w_ph_expired) begin
          w_state_next = S_WARM;
          w_load       = 1'b1;
          w_load_val   = PH_W'(WARM_CYCLES - 1);
        end
      end
      S_WARM: begin
        if (w_ph_expired) begin
          w_state_next = S_RST2;
          w_load       = 1'b1;
          w_load_val   = PH_W'(RST_CYCLES - 1);
        end
      end
      S_RST2: begin
        if (w_ph_expired)
          w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_run_exit)
          w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_first_cycle <= 1'b0;
      r_first_instr <= '0;
      r_cycle_cnt   <= '0;
      r_status      <= ST_NONE;
      r_done        <= 1'b0;
      r_reset_ok    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_first_cycle <= (w_state_next != r_state);

      if (w_start_ok) begin
        r_done      <= 1'b0;
        r_status    <= ST_NONE;
        r_reset_ok  <= 1'b0;
        r_cycle_cnt <= '0;
      end

      if (r_state == S_WARM && r_first_cycle)
        r_first_instr <= i_instruction;

      if (r_state == S_RST2 && w_state_next == S_RUN)
        r_cycle_cnt <= '0;

      // reset_ok is loaded even when the first RUN cycle is also the last.
      if (r_state == S_RUN) begin
        r_cycle_cnt <= w_cnt_inc;
        if (r_first_cycle)
          r_reset_ok <= (i_instruction == r_first_instr);
        if (w_run_exit) begin
          r_done   <= 1'b1;
          r_status <= exit_status(w_halt, w_stall, w_timeout);
        end
      end
    end
  end

  assign o_core_rst  = !(r_state == S_WARM || r_state == S_RUN);
  assign o_busy      = (r_state == S_RST1) || (r_state == S_WARM) ||
                       (r_state == S_RST2) || (r_state == S_RUN);
  assign o_done      = r_done;
  assign o_status    = r_status;
  assign o_reset_ok  = r_reset_ok;
  assign o_cycle_cnt = r_cycle_cnt;

endmodule
